// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, memory and writeback signal bundle for mem_access_unit
//
// Purpose: groups the load/store request port, the single-outstanding memory
// port and the register-file writeback port into one interface.
// Modports:
//   master - the load/store unit (accepts requests, masters the memory port,
//            drives writeback and completion status)
//   slave  - the surrounding pipeline, memory and register file
// Signal summary:
//   request : req_valid, req_ready, is_store, funct3, base_addr, offset,
//             store_data, rd_addr
//   memory  : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_ack, mem_rdata
//   wb/stat : wb_en, wb_addr, wb_data, done, err_code

interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base_addr;
    logic [11:0] offset;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done;
    logic [1:0]  err_code;

    modport master (
        input  req_valid, is_store, funct3, base_addr, offset, store_data, rd_addr,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata,
        output wb_en, wb_addr, wb_data, done, err_code
    );

    modport slave (
        output req_valid, is_store, funct3, base_addr, offset, store_data, rd_addr,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata,
        input  wb_en, wb_addr, wb_data, done, err_code
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store execution stage with lane steering and timeout
//
// Purpose: accepts one load/store request at a time, computes the effective
// address, checks funct3 legality and alignment, runs one request/ack memory
// access, steers store lanes, extends load data and writes it back.
// Ports:
//   i_clk    - clock, all state changes on the rising edge
//   i_reset  - asynchronous active-low reset
//   io_bus   - mem_access_unit_if.master (request, memory, writeback, status)
// Parameters:
//   TIMEOUT_CYCLES - ACCESS cycles without mem_ack before abort (1..255)

module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mem_access_unit_if.master  io_bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Last count value before expiry: the abort happens on the edge that
    // would make the counter reach TIMEOUT_CYCLES.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;

    logic        r_req_ready, w_req_ready;
    logic        r_mem_req, w_mem_req;
    logic        r_mem_we, w_mem_we;
    logic [31:0] r_mem_addr, w_mem_addr;
    logic [31:0] r_mem_wdata, w_mem_wdata;
    logic [3:0]  r_mem_wstrb, w_mem_wstrb;
    logic        r_wb_en, w_wb_en;
    logic [4:0]  r_wb_addr, w_wb_addr;
    logic [31:0] r_wb_data, w_wb_data;
    logic        r_done, w_done;
    logic [1:0]  r_err_code, w_err_code;

    // Request fields needed after the accept edge
    logic [7:0]  r_cnt, w_cnt;
    logic [2:0]  r_funct3, w_funct3;
    logic [1:0]  r_ea_lo, w_ea_lo;
    logic [4:0]  r_rd_addr, w_rd_addr;
    logic        r_is_store, w_is_store;

    logic [31:0] w_ea;
    logic        w_illegal;
    logic        w_misalign;
    logic [3:0]  w_st_strb;
    logic [31:0] w_st_data;
    logic [31:0] w_shifted;
    logic [31:0] w_load_val;

    // ------------------------------------------------------------------
    // Request decode (only meaningful while IDLE)
    // ------------------------------------------------------------------
    assign w_ea = io_bus.base_addr + {{20{io_bus.offset[11]}}, io_bus.offset};

    always_comb begin
        w_illegal = 1'b0;
        if (io_bus.is_store) begin
            w_illegal = (io_bus.funct3 > 3'b010);
        end else begin
            w_illegal = (io_bus.funct3 == 3'b011) || (io_bus.funct3[2:1] == 2'b11);
        end
    end

    // funct3[1:0] encodes size for every legal encoding: 00 byte, 01 half, 10 word
    assign w_misalign = ((io_bus.funct3[1:0] == 2'b01) && w_ea[0]) ||
                        ((io_bus.funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));

    always_comb begin
        w_st_strb = 4'b1111;
        w_st_data = io_bus.store_data;
        case (io_bus.funct3[1:0])
            2'b00: begin
                w_st_strb = 4'b0001 << w_ea[1:0];
                w_st_data = {4{io_bus.store_data[7:0]}};
            end
            2'b01: begin
                w_st_strb = 4'b0011 << w_ea[1:0];
                w_st_data = {2{io_bus.store_data[15:0]}};
            end
            default: begin
                w_st_strb = 4'b1111;
                w_st_data = io_bus.store_data;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction from the acknowledged read word
    // ------------------------------------------------------------------
    assign w_shifted = io_bus.mem_rdata >> {r_ea_lo, 3'b000};

    always_comb begin
        w_load_val = w_shifted;
        case (r_funct3)
            3'b000:  w_load_val = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_val = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_val = {16'd0, w_shifted[15:0]};
            default: w_load_val = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next state and next values of every registered output
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_wstrb = r_mem_wstrb;
        w_wb_en     = 1'b0;
        w_wb_addr   = r_wb_addr;
        w_wb_data   = r_wb_data;
        w_done      = 1'b0;
        w_err_code  = ERR_NONE;
        w_cnt       = r_cnt;
        w_funct3    = r_funct3;
        w_ea_lo     = r_ea_lo;
        w_rd_addr   = r_rd_addr;
        w_is_store  = r_is_store;

        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (io_bus.req_valid) begin
                    w_req_ready = 1'b0;
                    w_funct3    = io_bus.funct3;
                    w_ea_lo     = w_ea[1:0];
                    w_rd_addr   = io_bus.rd_addr;
                    w_is_store  = io_bus.is_store;
                    if (w_illegal) begin
                        w_state_nxt = S_DONE;
                        w_done      = 1'b1;
                        w_err_code  = ERR_ILLEGAL;
                    end else if (w_misalign) begin
                        w_state_nxt = S_DONE;
                        w_done      = 1'b1;
                        w_err_code  = ERR_MISALIGN;
                    end else begin
                        w_state_nxt = S_ACCESS;
                        w_mem_req   = 1'b1;
                        w_mem_we    = io_bus.is_store;
                        w_mem_addr  = {w_ea[31:2], 2'b00};
                        w_mem_wdata = io_bus.is_store ? w_st_data : 32'd0;
                        w_mem_wstrb = io_bus.is_store ? w_st_strb : 4'b0000;
                        w_cnt       = 8'd0;
                    end
                end
            end

            S_ACCESS: begin
                // An ack on the expiry cycle is checked first, so it wins.
                if (io_bus.mem_ack) begin
                    w_state_nxt = S_DONE;
                    w_done      = 1'b1;
                    w_err_code  = ERR_NONE;
                    if (!r_is_store && (r_rd_addr != 5'd0)) begin
                        w_wb_en   = 1'b1;
                        w_wb_addr = r_rd_addr;
                        w_wb_data = w_load_val;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = S_DONE;
                    w_done      = 1'b1;
                    w_err_code  = ERR_TIMEOUT;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
                if (w_state_nxt == S_DONE) begin
                    w_mem_req   = 1'b0;
                    w_mem_we    = 1'b0;
                    w_mem_addr  = 32'd0;
                    w_mem_wdata = 32'd0;
                    w_mem_wstrb = 4'b0000;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_req_ready = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_req_ready = 1'b1;
                w_mem_req   = 1'b0;
                w_mem_we    = 1'b0;
                w_mem_addr  = 32'd0;
                w_mem_wdata = 32'd0;
                w_mem_wstrb = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'b0000;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= 5'd0;
            r_wb_data   <= 32'd0;
            r_done      <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_cnt       <= 8'd0;
            r_funct3    <= 3'd0;
            r_ea_lo     <= 2'd0;
            r_rd_addr   <= 5'd0;
            r_is_store  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_wstrb <= w_mem_wstrb;
            r_wb_en     <= w_wb_en;
            r_wb_addr   <= w_wb_addr;
            r_wb_data   <= w_wb_data;
            r_done      <= w_done;
            r_err_code  <= w_err_code;
            r_cnt       <= w_cnt;
            r_funct3    <= w_funct3;
            r_ea_lo     <= w_ea_lo;
            r_rd_addr   <= w_rd_addr;
            r_is_store  <= w_is_store;
        end
    end

    assign io_bus.req_ready = r_req_ready;
    assign io_bus.mem_req   = r_mem_req;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.mem_wstrb = r_mem_wstrb;
    assign io_bus.wb_en     = r_wb_en;
    assign io_bus.wb_addr   = r_wb_addr;
    assign io_bus.wb_data   = r_wb_data;
    assign io_bus.done      = r_done;
    assign io_bus.err_code  = r_err_code;

endmodule
